// File: rtl/risc_datapath.sv
`default_nettype none
// -----------------------------------------------------------------------------
// risc_datapath : 32-bit single-bus datapath (register file, ALU, CON flag)
// Revision 1.0
// -----------------------------------------------------------------------------
module risc_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Read,
   input  logic             Write,
   input  logic             IncPC,
   input  logic [15:0]      R0_15_enable,
   input  logic [15:0]      R0_15_out,
   input  logic             PCin,
   input  logic             Zin,
   input  logic             MDRin,
   input  logic             MARin,
   input  logic             Yin,
   input  logic             HIin,
   input  logic             LOin,
   input  logic             IRin,
   input  logic             OutPortin,
   input  logic             PCout,
   input  logic             Zhighout,
   input  logic             Zlowout,
   input  logic             HIout,
   input  logic             LOout,
   input  logic             MDRout,
   input  logic             InPortout,
   input  logic             Cout,
   input  logic             BAout,
   input  logic             CONin,
   input  logic             Gra,
   input  logic             Grb,
   input  logic             Grc,
   input  logic             Rin,
   input  logic             Rout,
   input  logic [WIDTH-1:0] InPort_input,
   input  logic [WIDTH-1:0] Mdatain,
   output logic [WIDTH-1:0] OutPort_out,
   output logic [WIDTH-1:0] MAR_q,
   output logic [WIDTH-1:0] MDR_q,
   output logic             CON_out
);

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [5:0] SH_W    = 6'd32;

   logic [WIDTH-1:0]   regs_q [16];
   logic [WIDTH-1:0]   pc_q, pc_d, ir_q, mar_q, mdr_q, mdr_d, y_q, hi_q, lo_q;
   logic [WIDTH-1:0]   inport_q, outport_q;
   logic [2*WIDTH-1:0] z_q, z_d;
   logic               con_q, con_d;

   logic [WIDTH-1:0]   bus, c_sext, alu_lo, alu_hi;
   logic [3:0]         field;
   logic [15:0]        sel_dec, reg_drive, reg_load;
   logic               ba_zero;
   logic [4:0]         opcode, shamt;
   logic [2*WIDTH-1:0] mul_res;
   logic signed [WIDTH:0] div_a, div_b, quo, rem;
   logic [2:0]         unused_bits;

   assign unused_bits = {Write, quo[WIDTH], rem[WIDTH]};

   assign field     = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) | ({4{Grc}} & ir_q[18:15]);
   assign sel_dec   = 16'b1 << field;
   assign reg_drive = R0_15_out | ({16{Rout | BAout}} & sel_dec);
   assign reg_load  = R0_15_enable | ({16{Rin}} & sel_dec);
   assign ba_zero   = BAout && (field == 4'd0);
   assign c_sext    = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

   // Later assignments win, so sources are applied from lowest to highest priority.
   always_comb begin
      bus = '0;
      if (Cout)      bus = c_sext;
      if (InPortout) bus = inport_q;
      if (MDRout)    bus = mdr_q;
      if (PCout)     bus = pc_q;
      if (Zlowout)   bus = z_q[WIDTH-1:0];
      if (Zhighout)  bus = z_q[2*WIDTH-1:WIDTH];
      if (LOout)     bus = lo_q;
      if (HIout)     bus = hi_q;
      for (int k = 15; k >= 0; k--) begin
         if (reg_drive[k]) bus = (k == 0 && ba_zero) ? '0 : regs_q[k];
      end
   end

   assign opcode  = ir_q[31:27];
   assign shamt   = bus[4:0];
   assign mul_res = $signed({{WIDTH{y_q[WIDTH-1]}}, y_q}) * $signed({{WIDTH{bus[WIDTH-1]}}, bus});
   assign div_a   = {y_q[WIDTH-1], y_q};
   assign div_b   = {bus[WIDTH-1], bus};
   assign quo     = div_a / div_b;
   assign rem     = div_a % div_b;

   always_comb begin
      alu_lo = bus;
      alu_hi = '0;
      case (opcode)
         OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI, OP_BR: alu_lo = y_q + bus;
         OP_SUB:          alu_lo = y_q - bus;
         OP_AND, OP_ANDI: alu_lo = y_q & bus;
         OP_OR, OP_ORI:   alu_lo = y_q | bus;
         OP_ROR:          alu_lo = (y_q >> shamt) | (y_q << (SH_W - {1'b0, shamt}));
         OP_ROL:          alu_lo = (y_q << shamt) | (y_q >> (SH_W - {1'b0, shamt}));
         OP_SHR:          alu_lo = y_q >> shamt;
         OP_SHRA:         alu_lo = $signed(y_q) >>> shamt;
         OP_SHL:          alu_lo = y_q << shamt;
         OP_MUL:          {alu_hi, alu_lo} = mul_res;
         OP_DIV: begin
            // Divide by zero hands the dividend back in the remainder half.
            if (bus == '0) begin
               alu_lo = '0;
               alu_hi = y_q;
            end else begin
               alu_lo = quo[WIDTH-1:0];
               alu_hi = rem[WIDTH-1:0];
            end
         end
         OP_NEG:          alu_lo = '0 - bus;
         OP_NOT:          alu_lo = ~bus;
         default:         alu_lo = bus;
      endcase
   end

   assign z_d   = {alu_hi, alu_lo};
   assign mdr_d = Read ? Mdatain : bus;

   always_comb begin
      pc_d = pc_q;
      if (IncPC)     pc_d = pc_q + 1'b1;
      else if (PCin) pc_d = bus;
   end

   always_comb begin
      con_d = 1'b0;
      case (ir_q[20:19])
         2'b00:   con_d = (bus == '0);
         2'b01:   con_d = (bus != '0);
         2'b10:   con_d = ~bus[WIDTH-1];
         default: con_d = bus[WIDTH-1];
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int k = 0; k < 16; k++) regs_q[k] <= '0;
         pc_q      <= '0;
         ir_q      <= '0;
         mar_q     <= '0;
         mdr_q     <= '0;
         y_q       <= '0;
         z_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         inport_q  <= '0;
         outport_q <= '0;
         con_q     <= 1'b0;
      end else begin
         for (int k = 0; k < 16; k++) begin
            if (reg_load[k]) regs_q[k] <= bus;
         end
         pc_q     <= pc_d;
         inport_q <= InPort_input;
         if (IRin)      ir_q      <= bus;
         if (MARin)     mar_q     <= bus;
         if (MDRin)     mdr_q     <= mdr_d;
         if (Yin)       y_q       <= bus;
         if (Zin)       z_q       <= z_d;
         if (HIin)      hi_q      <= bus;
         if (LOin)      lo_q      <= bus;
         if (OutPortin) outport_q <= bus;
         if (CONin)     con_q     <= con_d;
      end
   end

   assign OutPort_out = outport_q;
   assign MAR_q       = mar_q;
   assign MDR_q       = mdr_q;
   assign CON_out     = con_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_datapath.sv
`default_nettype none
// tb_risc_datapath : directed and randomized checks of risc_datapath against a behavioural model.
module tb_risc_datapath;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Read, Write, IncPC;
   logic [15:0] R0_15_enable, R0_15_out;
   logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin;
   logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout, BAout;
   logic        CONin, Gra, Grb, Grc, Rin, Rout;
   logic [31:0] InPort_input, Mdatain;
   logic [31:0] OutPort_out, MAR_q, MDR_q;
   logic        CON_out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clock = ~Clock;

   risc_datapath #(.WIDTH(32)) dut (
      .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write), .IncPC(IncPC),
      .R0_15_enable(R0_15_enable), .R0_15_out(R0_15_out),
      .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin), .Yin(Yin),
      .HIin(HIin), .LOin(LOin), .IRin(IRin), .OutPortin(OutPortin),
      .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout),
      .LOout(LOout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
      .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .InPort_input(InPort_input), .Mdatain(Mdatain),
      .OutPort_out(OutPort_out), .MAR_q(MAR_q), .MDR_q(MDR_q), .CON_out(CON_out)
   );

   function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      logic [31:0] t;
      int n;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      n  = int'(b[4:0]);
      t  = a;
      case (op)
         5'd0, 5'd1, 5'd2, 5'd3, 5'd12, 5'd19: return {32'd0, 32'(sa + sb)};
         5'd4:        return {32'd0, 32'(sa - sb)};
         5'd5, 5'd13: return {32'd0, a & b};
         5'd6, 5'd14: return {32'd0, a | b};
         5'd7:  begin for (int k = 0; k < n; k++) t = {t[0], t[31:1]};    return {32'd0, t}; end
         5'd8:  begin for (int k = 0; k < n; k++) t = {t[30:0], t[31]};   return {32'd0, t}; end
         5'd9:  begin for (int k = 0; k < n; k++) t = {1'b0, t[31:1]};    return {32'd0, t}; end
         5'd10: begin for (int k = 0; k < n; k++) t = {t[31], t[31:1]};   return {32'd0, t}; end
         5'd11: begin for (int k = 0; k < n; k++) t = {t[30:0], 1'b0};    return {32'd0, t}; end
         5'd16: return 64'(sa * sb);
         5'd15: begin
            if (b == 32'd0) return {a, 32'd0};
            q = sa / sb;
            r = sa % sb;
            return {32'(r), 32'(q)};
         end
         5'd17: return {32'd0, 32'(-sb)};
         5'd18: return {32'd0, ~b};
         default: return {32'd0, b};
      endcase
   endfunction

   function automatic logic ref_con(input logic [1:0] c2, input logic [31:0] v);
      case (c2)
         2'd0:    return v == 32'd0;
         2'd1:    return v != 32'd0;
         2'd2:    return $signed(v) >= 0;
         default: return $signed(v) < 0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_ctrl();
      {Read, Write, IncPC, PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin} = '0;
      {PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout, BAout} = '0;
      {CONin, Gra, Grb, Grc, Rin, Rout} = '0;
      R0_15_enable = '0;
      R0_15_out    = '0;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
      clear_ctrl();
   endtask

   task automatic mdr_load(input logic [31:0] v);
      Mdatain = v; Read = 1'b1; MDRin = 1'b1; tick();
   endtask

   task automatic set_ir(input logic [31:0] v);
      mdr_load(v);
      MDRout = 1'b1; IRin = 1'b1; tick();
   endtask

   task automatic load_reg(input int k, input logic [31:0] v);
      mdr_load(v);
      MDRout = 1'b1; R0_15_enable[k] = 1'b1; tick();
   endtask

   // Caller asserts the bus source first; this captures the bus into OutPort.
   task automatic latch_out(output logic [31:0] v);
      OutPortin = 1'b1; tick();
      v = OutPort_out;
   endtask

   task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] zl, output logic [31:0] zh);
      set_ir({op, 27'd0});
      mdr_load(a);
      MDRout = 1'b1; Yin = 1'b1; tick();
      mdr_load(b);
      MDRout = 1'b1; Zin = 1'b1; tick();
      Zlowout = 1'b1;  latch_out(zl);
      Zhighout = 1'b1; latch_out(zh);
   endtask

   initial begin
      logic [31:0] v, a, b, zl, zh;
      logic [63:0] e;
      logic [4:0]  op;
      logic [1:0]  c2;

      clear_ctrl();
      Reset = 1'b0; InPort_input = 32'd0; Mdatain = 32'd0;
      repeat (2) @(posedge Clock);
      #3 Reset = 1'b1;

      check("rst_outport", OutPort_out, 32'd0);
      check("rst_mar", MAR_q, 32'd0);
      check("rst_mdr", MDR_q, 32'd0);
      check("rst_con", {31'd0, CON_out}, 32'd0);

      // Instruction fetch
      PCout = 1'b1; MARin = 1'b1; tick();
      check("fetch_mar", MAR_q, 32'd0);
      Mdatain = 32'h6197FFFD; Read = 1'b1; MDRin = 1'b1; tick();
      check("fetch_mdr", MDR_q, 32'h6197FFFD);
      MDRout = 1'b1; IRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; tick();
      PCout = 1'b1; MARin = 1'b1; tick();
      check("fetch_pc", MAR_q, 32'd1);
      Cout = 1'b1; latch_out(v);
      check("ir_cconst", v, 32'hFFFFFFFD);

      // addi R3,R2,-3
      load_reg(2, 32'd5);
      Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; tick();
      Cout = 1'b1; Zin = 1'b1; tick();
      Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; tick();
      R0_15_out[3] = 1'b1; latch_out(v);
      check("addi_r3", v, 32'd2);
      Zhighout = 1'b1; latch_out(v);
      check("addi_zhi", v, 32'd0);

      // mul through HI/LO
      load_reg(4, 32'hFFFFFFFE);
      load_reg(5, 32'd3);
      set_ir({5'b10000, 27'd0});
      R0_15_out[4] = 1'b1; Yin = 1'b1; tick();
      R0_15_out[5] = 1'b1; Zin = 1'b1; tick();
      Zhighout = 1'b1; HIin = 1'b1; tick();
      Zlowout = 1'b1; LOin = 1'b1; tick();
      HIout = 1'b1; latch_out(v);
      check("mul_hi", v, 32'hFFFFFFFF);
      LOout = 1'b1; latch_out(v);
      check("mul_lo", v, 32'hFFFFFFFA);

      run_alu(5'b01111, 32'd7, 32'hFFFFFFFE, zl, zh);
      check("div_quo", zl, 32'hFFFFFFFD);
      check("div_rem", zh, 32'd1);
      run_alu(5'b01111, 32'd9, 32'd0, zl, zh);
      check("div0_lo", zl, 32'd0);
      check("div0_hi", zh, 32'd9);
      run_alu(5'b01010, 32'h80000000, 32'd4, zl, zh);
      check("shra", zl, 32'hF8000000);
      run_alu(5'b00111, 32'd1, 32'd1, zl, zh);
      check("ror", zl, 32'h80000000);

      // BAout with field 0 forces zero; Rout still reads R0
      load_reg(0, 32'h55);
      set_ir(32'd0);
      Gra = 1'b1; BAout = 1'b1; latch_out(v);
      check("baout_r0", v, 32'd0);
      Gra = 1'b1; Rout = 1'b1; latch_out(v);
      check("rout_r0", v, 32'h55);

      mdr_load(32'd0);
      MDRout = 1'b1; CONin = 1'b1; tick();
      check("con_eq_zero", {31'd0, CON_out}, 32'd1);
      mdr_load(32'd5);
      MDRout = 1'b1; CONin = 1'b1; tick();
      check("con_eq_five", {31'd0, CON_out}, 32'd0);

      // Simultaneous register writes
      mdr_load(32'hA5A50001);
      MDRout = 1'b1; R0_15_enable = 16'h00C0; tick();
      R0_15_out[6] = 1'b1; latch_out(v);
      check("multi_r6", v, 32'hA5A50001);
      R0_15_out[7] = 1'b1; latch_out(v);
      check("multi_r7", v, 32'hA5A50001);

      InPort_input = $urandom; tick();
      InPortout = 1'b1; latch_out(v);
      check("inport", v, InPort_input);

      IncPC = 1'b1; tick();
      PCout = 1'b1; MARin = 1'b1; tick();
      check("incpc", MAR_q, 32'd2);

      for (int i = 0; i < 40; i++) begin
         op = 5'($urandom_range(0, 31));
         a  = $urandom;
         b  = (i % 8 == 0) ? 32'd0 : $urandom;
         run_alu(op, a, b, zl, zh);
         e = ref_alu(op, a, b);
         check($sformatf("alu_lo op=%0d a=%h b=%h", op, a, b), zl, e[31:0]);
         check($sformatf("alu_hi op=%0d a=%h b=%h", op, a, b), zh, e[63:32]);
      end

      for (int i = 0; i < 16; i++) begin
         c2 = 2'($urandom_range(0, 3));
         v  = (i % 4 == 0) ? 32'd0 : $urandom;
         set_ir({11'd0, c2, 19'd0});
         mdr_load(v);
         MDRout = 1'b1; CONin = 1'b1; tick();
         check($sformatf("con c2=%0d v=%h", c2, v), {31'd0, CON_out}, {31'd0, ref_con(c2, v)});
      end

      // Make state nonzero, then reset between clock edges
      run_alu(5'b00011, 32'd1, 32'd1, zl, zh);
      set_ir(32'd0);
      mdr_load(32'd0);
      MDRout = 1'b1; CONin = 1'b1; tick();
      mdr_load(32'h1234);
      MDRout = 1'b1; latch_out(v);
      check("pre_rst_outport", OutPort_out, 32'h1234);
      check("pre_rst_con", {31'd0, CON_out}, 32'd1);
      check("pre_rst_mar", MAR_q, 32'd2);

      @(posedge Clock);
      #3 Reset = 1'b0;
      #1;
      check("async_rst_outport", OutPort_out, 32'd0);
      check("async_rst_mar", MAR_q, 32'd0);
      check("async_rst_mdr", MDR_q, 32'd0);
      check("async_rst_con", {31'd0, CON_out}, 32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      R0_15_out[3] = 1'b1; latch_out(v);
      check("rst_r3", v, 32'd0);
      Zlowout = 1'b1; latch_out(v);
      check("rst_zlo", v, 32'd0);
      PCout = 1'b1; MARin = 1'b1; tick();
      check("rst_pc", MAR_q, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/risc_datapath.md
Name: risc_datapath

Overview:
- 32-bit single-bus datapath for the 5-bit-opcode RISC CPU.
- Contains the register file, special registers, bus, ALU, register select/encode logic and the branch condition flip-flop.
- The external control sequencer drives every control strobe.
- Memory is external: MDR takes read data from Mdatain, and MAR/MDR contents are exported.

Parameters:
- WIDTH, 32, bus/register width (fixed at 32).

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Read  in  1  MDR input mux: 1=Mdatain, 0=bus
- Write  in  1  memory write strobe; no internal effect
- IncPC  in  1  PC increment
- R0_15_enable  in  16  direct register write enables
- R0_15_out  in  16  direct register bus drives
- PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin  in  1 each  register loads
- PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout, BAout  in  1 each  bus drives
- CONin  in  1  load CON flip-flop
- Gra, Grb, Grc  in  1 each  IR register-field selects
- Rin, Rout  in  1 each  selected register write / read
- InPort_input  in  32  external input port data
- Mdatain  in  32  memory read data
- OutPort_out  out  32  output port register
- MAR_q  out  32  memory address
- MDR_q  out  32  memory write data
- CON_out  out  1  branch condition flag

Behaviour:
- **Reset:** Reset=0 asynchronously clears all registers and outputs to 0: R0-R15, PC, IR, MAR, MDR, Y, Z[63:0], HI, LO, InPort, OutPort, CON.
- **Bus:** combinational 32-bit mux.
  - Sources, in priority order: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C.
  - No source asserted: bus = 0.
- **Register drive:** Rk drives the bus if R0_15_out[k], or if (Rout|BAout) and the decoded select = k.
  - When BAout selects R0, the bus value is 0.
- **Select/encode:** field = (Gra?IR[26:23]:0) | (Grb?IR[22:19]:0) | (Grc?IR[18:15]:0).
  - Rin writes the register named by the field.
  - Register k loads on the clock when R0_15_enable[k] | (Rin & field==k).
- **C constant:** C = sign-extend IR[18:0].
- **Register loads:** all loads take the bus on the rising clock.
  - MDR loads (Read ? Mdatain : bus) when MDRin.
  - InPort register samples InPort_input every clock.
  - OutPort loads on OutPortin.
- **PC:** if IncPC, PC <= PC+1 (priority over PCin); else if PCin, PC <= bus.
- **ALU:** combinational; A = Y, B = bus, op = IR[31:27]; result is 64 bits; Zin latches it into Z.
  - Z[63:32] = 0 except for mul/div.
  - 00000 ld, 00001 ldi, 00010 st, 00011 add, 01100 addi, 10011 br: A+B, 32-bit wrap.
  - 00100 sub: A-B.
  - 00101 and / 01101 andi: A&B.
  - 00110 or / 01110 ori: A|B.
  - Rotates and shifts use amount B[4:0]: 00111 ror, 01000 rol, 01001 shr (logical), 01010 shra (arithmetic), 01011 shl.
  - 10000 mul: signed A*B, full 64-bit result.
  - 01111 div: signed, truncating; Z[31:0] = quotient, Z[63:32] = remainder (sign of dividend).
  - Divide by zero: Z[31:0] = 0, Z[63:32] = A.
  - 10001 neg: -B. 10010 not: ~B.
  - All other opcodes: Z = {32'b0, B}.
- **CON:** on CONin, CON <= condition on the bus value, with C2 = IR[20:19].
  - 00: bus==0. 01: bus!=0. 10: bus[31]==0. 11: bus[31]==1.
- **Simultaneous events:**
  - A register may load its own bus value in the same cycle (read-before-write at the edge).
  - Multiple write enables may load simultaneously.
- **Mid-operation reset:** asynchronous clear; no partial state survives.

Test Plan:
- Fetch: PC=0, Mdatain=0x6197FFFD.
  - T0: PCout, MARin -> MAR_q=0.
  - T1: Read, MDRin -> MDR=0x6197FFFD.
  - T2: MDRout, IRin, PCin, IncPC -> IR=0x6197FFFD, PC=1.
- addi R3,R2,-3 with R2=5 (preloaded via Read/MDRin, then MDRout with R0_15_enable[2]):
  - Grb, Rout, Yin; then Cout, Zin; then Zlowout, Gra, Rin -> R3=2, Z[63:32]=0.
- mul: R4=0xFFFFFFFE, R5=3, opcode 10000, R4->Y, R5 with Zin -> Zhigh->HI=0xFFFFFFFF, Zlow->LO=0xFFFFFFFA.
- div: 7 / 0xFFFFFFFE (-2) -> LO=0xFFFFFFFD, HI=1. Divide by zero: 9/0 -> Zlow=0, Zhigh=9.
- Shifts, BAout, CON:
  - shra 0x80000000 by 4 -> 0xF8000000.
  - ror 0x00000001 by 1 -> 0x80000000.
  - BAout with field 0 while R0=0x55 -> bus 0.
  - CON with IR[20:19]=00 and bus 0 -> CON_out=1; bus 5 -> 0.
- Reset: assert Reset=0 between clock edges with R3, PC, Z nonzero -> all cleared immediately; OutPort_out=0.
